// File: rtl/sampling_pkg.sv
// Constants and helpers shared by the coefficient encode and sampling paths.
package sampling_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned BEAT_W  = 128;
    localparam int unsigned KEEP_W  = 16;

    // Number of bytes needed to hold the given number of bits.
    function automatic int unsigned ceil_bytes(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register carrying data, keep and last.
module stream_out_reg
    import sampling_pkg::*;
#(
    parameter int unsigned DW = BEAT_W,
    parameter int unsigned KW = KEEP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [KW-1:0] keep_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          free_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [KW-1:0] keep_o,
    output logic          last_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [KW-1:0] keep_q;
    logic          last_q;

    // Slot can be refilled in the same cycle its current beat is taken.
    assign free_o = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/byte_encode.sv
// ByteEncode_D: packs D-bit coefficients little-endian into 128-bit beats with keep/last.
module byte_encode
    import sampling_pkg::*;
#(
    parameter int unsigned Q           = KYBER_Q,
    parameter int unsigned COEFF_WIDTH = 13,
    parameter int unsigned D           = 12,
    parameter int unsigned N           = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   done_o,
    output logic                   err_o,
    input  logic [COEFF_WIDTH-1:0] coeff_i,
    input  logic                   coeff_valid_i,
    output logic                   coeff_ready_o,
    output logic [BEAT_W-1:0]      data_o,
    output logic                   valid_o,
    output logic                   last_o,
    output logic [KEEP_W-1:0]      keep_o,
    input  logic                   ready_i
);

    localparam int unsigned ACC_W  = 140;
    localparam int unsigned FILL_W = 8;
    localparam int unsigned CNT_W  = $clog2(N + 1);

    localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);
    localparam logic [FILL_W-1:0] BEAT_FILL = FILL_W'(BEAT_W);
    localparam logic [FILL_W-1:0] D_FILL    = FILL_W'(D);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_shift;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_shift;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               draining;
    logic               slot_free;
    logic               load_full;
    logic               load_part;
    logic               beat_load;
    logic               range_bad;
    logic [KEEP_W-1:0]  beat_keep;
    logic               beat_last;

    assign coeff_ready_o = (state_q == StRun) && (cnt_q < N_CNT) && (fill_q < BEAT_FILL);
    assign accept        = coeff_ready_o && coeff_valid_i;
    assign draining      = (state_q == StRun) || (state_q == StFlush);
    assign load_full     = draining && (fill_q >= BEAT_FILL) && slot_free;
    assign load_part     = (state_q == StFlush) && (fill_q != '0) && (fill_q < BEAT_FILL)
                           && slot_free;
    assign beat_load     = load_full || load_part;

    always_comb begin
        if (D == 12) begin
            range_bad = 32'(coeff_i) >= Q;
        end else begin
            range_bad = 32'(coeff_i) >= (32'd1 << D);
        end
    end

    // Shift out a full beat first, then place the new coefficient at the post-shift fill.
    always_comb begin
        acc_shift  = load_full ? (acc_q >> BEAT_W) : acc_q;
        fill_shift = load_full ? (fill_q - BEAT_FILL) : fill_q;
        acc_d      = acc_shift;
        fill_d     = fill_shift;
        if (accept) begin
            acc_d  = acc_shift | (ACC_W'(coeff_i[D-1:0]) << fill_shift);
            fill_d = fill_shift + D_FILL;
        end
        if (load_part) begin
            acc_d  = '0;
            fill_d = '0;
        end
    end

    // Bits above fill are always zero, so a partial beat is already zero-padded.
    always_comb begin
        if (load_full) begin
            beat_keep = '1;
        end else begin
            beat_keep = KEEP_W'((32'd1 << ceil_bytes(32'(fill_q))) - 32'd1);
        end
        beat_last = load_part || ((fill_shift == '0) && (cnt_q == N_CNT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q   <= '0;
                        fill_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun, StFlush: begin
                    acc_q  <= acc_d;
                    fill_q <= fill_d;
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (state_q == StRun && cnt_q == N_CNT) begin
                        state_q <= StFlush;
                    end
                    if (state_q == StFlush && valid_o && last_o && ready_i) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign done_o = done_q;
    assign err_o  = err_q;

    stream_out_reg #(
        .DW (BEAT_W),
        .KW (KEEP_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (beat_load),
        .data_i  (acc_q[BEAT_W-1:0]),
        .keep_i  (beat_keep),
        .last_i  (beat_last),
        .ready_i (ready_i),
        .free_o  (slot_free),
        .valid_o (valid_o),
        .data_o  (data_o),
        .keep_o  (keep_o),
        .last_o  (last_o)
    );

endmodule
